ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port data RAM between two requesters:
  - requester 0: the processor core load/store path.
  - requester 1: an auxiliary master (port DMA / debug loader).
- Sits between the requesters and the RAM's CE/ADDR/DATA_IN/DATA_OUT pins.
- Provides a registered request/grant handshake, round-robin tie-break and a burst limit for fairness.
- Drives a core stall so the program counter CE can be gated while the core waits.

Parameters:
- DATA_WIDTH, 8, RAM data width.
- ADDR_WIDTH, 8, RAM address width.
- MAX_BURST, 4, maximum consecutive transfers granted to one owner while the other requester waits (>=1).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ0 / REQ1  input  1  access request, requester 0 / 1.
- WE0 / WE1  input  1  1 = write, 0 = read.
- ADDR0 / ADDR1  input  ADDR_WIDTH  access address.
- WDATA0 / WDATA1  input  DATA_WIDTH  write data.
- GNT0 / GNT1  output  1  registered grant.
- RVALID0 / RVALID1  output  1  one-cycle read-data-valid pulse.
- RDATA0 / RDATA1  output  DATA_WIDTH  registered read data.
- STALL0  output  1  REQ0 & ~GNT0 (combinational).
- RAM_CE  output  1  RAM write enable.
- RAM_ADDR  output  ADDR_WIDTH  RAM address.
- RAM_DIN  output  DATA_WIDTH  RAM write data.
- RAM_DOUT  input  DATA_WIDTH  RAM combinational read data.

Behaviour:
- **Reset** (RESET=1 at an edge):
  - State IDLE; GNT0/1, RVALID0/1 = 0; RDATA0/1 = 0; burst count 0.
  - LAST=1, so requester 0 wins the first tie.
  - RAM_CE is forced 0 in any cycle RESET=1, so a write in progress is suppressed. Reset mid-burst aborts without a RAM write.
- **FSM states:** IDLE, OWN0, OWN1. GNTx = (state==OWNx), decoded from a register.
- **IDLE transitions:**
  - Both REQ -> OWN(not LAST).
  - Only REQx -> OWNx.
  - None -> IDLE.
- **Latency:** a request seen at edge N gives GNT high after edge N. Minimum one wait cycle from IDLE.
- **Transfer:** a cycle with GNTx=1 and REQx=1. In that cycle:
  - RAM_ADDR = ADDRx; RAM_DIN = WDATAx; RAM_CE = WEx.
  - On a read, RAM_DOUT is captured into RDATAx at the edge; RVALIDx=1 the following cycle, for exactly one cycle.
  - Writes produce no RVALID.
  - RDATAx holds its value until the next read by that requester.
- **Requester rule:** the requester holds ADDR/WE/WDATA stable while REQ=1 and GNT=0. Raising and dropping REQ with no grant is allowed and has no effect.
- **OWNx transitions** (evaluated at each edge, cnt = transfers completed this ownership, including the current one):
  - REQx=0 and REQy=1 -> OWNy.
  - REQx=0 and REQy=0 -> IDLE.
  - REQx=1, REQy=1 and cnt==MAX_BURST -> OWNy (handover with no idle bubble).
  - Otherwise stay in OWNx.
- **LAST** is set to x on leaving OWNx.
- **Burst count:**
  - Cleared on any state change.
  - Increments per transfer and saturates at MAX_BURST.
  - While the other requester is idle, ownership is unlimited.
- **Idle outputs:** RAM_CE=0, RAM_ADDR=0, RAM_DIN=0.
- **Ordering:** a write and a read to the same address by different owners complete in grant order; there is no bypass.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined:
  - Requester 0 has strict priority: in IDLE, ties go to 0 regardless of LAST.
  - In OWN1, REQ0=1 forces handover to OWN0 after the current transfer (effective burst limit 1 for requester 1).
  - In OWN0, MAX_BURST is ignored; core keeps ownership while REQ0=1.
- Undefined: round-robin with MAX_BURST as above.

Test Plan:
1. **Reset:** RESET=1 for 2 cycles with REQ0=1, WE0=1 -> RAM_CE=0 and GNT0=0 throughout. After release, GNT0=1 one cycle later.
2. **Core write then read:**
   - REQ0=1, WE0=1, ADDR0=0x10, WDATA0=0xA5 -> one cycle with RAM_CE=1, RAM_ADDR=0x10, RAM_DIN=0xA5.
   - Then WE0=0 -> RVALID0 pulses one cycle, RDATA0=0xA5.
3. **Tie after reset:** REQ0 and REQ1 rise together, each holds for 1 transfer -> GNT0 first, then GNT1 with no bubble. A second simultaneous tie from IDLE -> GNT1 first.
4. **Burst fairness:** REQ0 held 10 cycles, REQ1 raised concurrently -> exactly 4 core transfers, then GNT1. STALL0=1 during aux ownership; core resumes after REQ1 drops.
5. **Release:** owner drops REQ while other idle -> state IDLE, GNT falls next cycle, RAM_CE=0.
6. **ARB_FIXED_PRIO_EN:**
   - Aux owning, REQ0 rises -> aux completes 1 transfer, then GNT0.
   - Core with REQ0 held 10 cycles and REQ1=1 -> 10 uninterrupted core transfers.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bundle of requester handshakes and RAM pins shared by the arbiter and its
// surroundings; the arbiter uses the slave view.
interface ram_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  REQ0;
  logic                  REQ1;
  logic                  WE0;
  logic                  WE1;
  logic [ADDR_WIDTH-1:0] ADDR0;
  logic [ADDR_WIDTH-1:0] ADDR1;
  logic [DATA_WIDTH-1:0] WDATA0;
  logic [DATA_WIDTH-1:0] WDATA1;
  logic                  GNT0;
  logic                  GNT1;
  logic                  RVALID0;
  logic                  RVALID1;
  logic [DATA_WIDTH-1:0] RDATA0;
  logic [DATA_WIDTH-1:0] RDATA1;
  logic                  STALL0;
  logic                  RAM_CE;
  logic [ADDR_WIDTH-1:0] RAM_ADDR;
  logic [DATA_WIDTH-1:0] RAM_DIN;
  logic [DATA_WIDTH-1:0] RAM_DOUT;

  modport slave (
    input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, RAM_DOUT,
    output GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, STALL0,
           RAM_CE, RAM_ADDR, RAM_DIN
  );

  modport master (
    output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, RAM_DOUT,
    input  GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, STALL0,
           RAM_CE, RAM_ADDR, RAM_DIN
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port RAM: registered grants, round-robin
// tie-break and a burst limit. Define ARB_FIXED_PRIO_EN for strict core priority.
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  ram_arbiter_if.slave  bus
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

`ifdef ARB_FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_gnt0;
  logic                  r_gnt1;
  logic                  r_last;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_now;
  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic                  w_xfer0;
  logic                  w_xfer1;
  logic                  w_yield0;
  logic                  w_yield1;
  logic                  w_ram_ce;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_din;

  assign w_xfer0 = r_gnt0 & bus.REQ0;
  assign w_xfer1 = r_gnt1 & bus.REQ1;

  // Transfers in this ownership including the one happening now, saturated.
  assign w_cnt_now = (r_cnt == MAX_CNT) ? MAX_CNT : (r_cnt + CW'(w_xfer0 | w_xfer1));

  assign w_yield0 = bus.REQ1 & ~FIXED_PRIO & (w_cnt_now == MAX_CNT);
  assign w_yield1 = bus.REQ0 & (FIXED_PRIO | (w_cnt_now == MAX_CNT));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.REQ0 & bus.REQ1) begin
          w_next = (FIXED_PRIO | r_last) ? OWN0 : OWN1;
        end else if (bus.REQ0) begin
          w_next = OWN0;
        end else if (bus.REQ1) begin
          w_next = OWN1;
        end else begin
          w_next = IDLE;
        end
      end
      OWN0: begin
        if (!bus.REQ0) begin
          w_next = bus.REQ1 ? OWN1 : IDLE;
        end else if (w_yield0) begin
          w_next = OWN1;
        end else begin
          w_next = OWN0;
        end
      end
      OWN1: begin
        if (!bus.REQ1) begin
          w_next = bus.REQ0 ? OWN0 : IDLE;
        end else if (w_yield1) begin
          w_next = OWN0;
        end else begin
          w_next = OWN1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Ownership state, grants, burst count, tie-break memory and read returns.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_state <= w_next;
      r_gnt0  <= (w_next == OWN0);
      r_gnt1  <= (w_next == OWN1);
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_now;
      end
      if ((r_state == OWN0) && (w_next != OWN0)) begin
        r_last <= 1'b0;
      end else if ((r_state == OWN1) && (w_next != OWN1)) begin
        r_last <= 1'b1;
      end else begin
        r_last <= r_last;
      end
      r_rvalid0 <= w_xfer0 & ~bus.WE0;
      r_rvalid1 <= w_xfer1 & ~bus.WE1;
      if (w_xfer0 & ~bus.WE0) begin
        r_rdata0 <= bus.RAM_DOUT;
      end
      if (w_xfer1 & ~bus.WE1) begin
        r_rdata1 <= bus.RAM_DOUT;
      end
    end
  end

  // RAM pins follow the granted requester; reset suppresses any write.
  always_comb begin
    w_ram_ce   = 1'b0;
    w_ram_addr = '0;
    w_ram_din  = '0;
    if (!RESET && w_xfer0) begin
      w_ram_ce   = bus.WE0;
      w_ram_addr = bus.ADDR0;
      w_ram_din  = bus.WDATA0;
    end else if (!RESET && w_xfer1) begin
      w_ram_ce   = bus.WE1;
      w_ram_addr = bus.ADDR1;
      w_ram_din  = bus.WDATA1;
    end else begin
      w_ram_ce   = 1'b0;
      w_ram_addr = '0;
      w_ram_din  = '0;
    end
  end

  assign bus.GNT0     = r_gnt0;
  assign bus.GNT1     = r_gnt1;
  assign bus.RVALID0  = r_rvalid0;
  assign bus.RVALID1  = r_rvalid1;
  assign bus.RDATA0   = r_rdata0;
  assign bus.RDATA1   = r_rdata1;
  assign bus.STALL0   = bus.REQ0 & ~r_gnt0;
  assign bus.RAM_CE   = w_ram_ce;
  assign bus.RAM_ADDR = w_ram_addr;
  assign bus.RAM_DIN  = w_ram_din;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with an ownership-level reference model and a
// RAM behind the arbiter; honours ARB_FIXED_PRIO_EN when defined.
module tb_ram_arbiter;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MAX_BURST(MAXB)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  logic [7:0] ram [256];
  assign bus.RAM_DOUT = ram[bus.RAM_ADDR];
  always @(posedge clk) if (bus.RAM_CE) ram[bus.RAM_ADDR] <= bus.RAM_DIN;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner -1 (none), 0 or 1.
  int         m_own = -1;
  int         m_last = 1;
  int         m_cnt = 0;
  bit         m_valid = 1'b0;
  bit         m_rv0 = 1'b0, m_rv1 = 1'b0;
  logic [7:0] m_rd0 = 8'h00, m_rd1 = 8'h00;
  logic [7:0] m_mem [256];

  logic       s_gnt0, s_gnt1, s_ce, s_rvalid0, s_rvalid1, s_stall0;
  logic [7:0] s_addr, s_din, s_rdata0, s_rdata1;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit t0, t1;
    int done, nxt;
    if (rst) begin
      m_own = -1; m_last = 1; m_cnt = 0; m_valid = 1'b1;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = 8'h00; m_rd1 = 8'h00;
    end else begin
      t0 = (m_own == 0) && bus.REQ0;
      t1 = (m_own == 1) && bus.REQ1;
      m_rv0 = t0 && !bus.WE0;
      m_rv1 = t1 && !bus.WE1;
      if (m_rv0) m_rd0 = m_mem[bus.ADDR0];
      if (m_rv1) m_rd1 = m_mem[bus.ADDR1];
      if (t0 && bus.WE0) m_mem[bus.ADDR0] = bus.WDATA0;
      if (t1 && bus.WE1) m_mem[bus.ADDR1] = bus.WDATA1;
      done = m_cnt + ((t0 || t1) ? 1 : 0);
      if (done > MAXB) done = MAXB;
      if (m_own == -1) begin
        if (bus.REQ0 && bus.REQ1) nxt = (FIXED || m_last == 1) ? 0 : 1;
        else if (bus.REQ0) nxt = 0;
        else if (bus.REQ1) nxt = 1;
        else nxt = -1;
      end else if (m_own == 0) begin
        if (!bus.REQ0) nxt = bus.REQ1 ? 1 : -1;
        else if (bus.REQ1 && !FIXED && done == MAXB) nxt = 1;
        else nxt = 0;
      end else begin
        if (!bus.REQ1) nxt = bus.REQ0 ? 0 : -1;
        else if (bus.REQ0 && (FIXED || done == MAXB)) nxt = 0;
        else nxt = 1;
      end
      if (nxt != m_own) begin
        if (m_own != -1) m_last = m_own;
        m_cnt = 0;
      end else begin
        m_cnt = done;
      end
      m_own = nxt;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit t0, t1;
    logic ece;
    logic [7:0] eaddr, edin;
    @(negedge clk);
    s_gnt0 = bus.GNT0;       s_gnt1 = bus.GNT1;
    s_ce = bus.RAM_CE;       s_addr = bus.RAM_ADDR;   s_din = bus.RAM_DIN;
    s_rvalid0 = bus.RVALID0; s_rvalid1 = bus.RVALID1;
    s_rdata0 = bus.RDATA0;   s_rdata1 = bus.RDATA1;   s_stall0 = bus.STALL0;
    t0 = !rst && m_valid && (m_own == 0) && bus.REQ0;
    t1 = !rst && m_valid && (m_own == 1) && bus.REQ1;
    ece   = t0 ? bus.WE0    : (t1 ? bus.WE1    : 1'b0);
    eaddr = t0 ? bus.ADDR0  : (t1 ? bus.ADDR1  : 8'h00);
    edin  = t0 ? bus.WDATA0 : (t1 ? bus.WDATA1 : 8'h00);
    chk("ram_ce", 32'(s_ce), 32'(ece));
    if (m_valid) begin
      chk("gnt0", 32'(s_gnt0), 32'(m_own == 0));
      chk("gnt1", 32'(s_gnt1), 32'(m_own == 1));
      chk("stall0", 32'(s_stall0), 32'(bus.REQ0 && m_own != 0));
      chk("rvalid0", 32'(s_rvalid0), 32'(m_rv0));
      chk("rvalid1", 32'(s_rvalid1), 32'(m_rv1));
      chk("rdata0", 32'(s_rdata0), 32'(m_rd0));
      chk("rdata1", 32'(s_rdata1), 32'(m_rd1));
      if (!rst) begin
        chk("ram_addr", 32'(s_addr), 32'(eaddr));
        chk("ram_din", 32'(s_din), 32'(edin));
      end
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int run0;
    bit seen1;
    bus.REQ0 = 1'b1; bus.WE0 = 1'b1; bus.ADDR0 = 8'h33; bus.WDATA0 = 8'h77;
    bus.REQ1 = 1'b0; bus.WE1 = 1'b0; bus.ADDR1 = 8'h00; bus.WDATA1 = 8'h00;

    // Reset held two cycles with a pending core write.
    cycle();  chk("rst_ce_a", 32'(s_ce), 32'd0);
    cycle();  chk("rst_ce_b", 32'(s_ce), 32'd0);  chk("rst_gnt0", 32'(s_gnt0), 32'd0);
    rst = 1'b0;
    cycle();  chk("wait_gnt0", 32'(s_gnt0), 32'd0);
    cycle();  chk("first_gnt0", 32'(s_gnt0), 32'd1);

    // Core write then read of 0x10.
    bus.ADDR0 = 8'h10; bus.WDATA0 = 8'hA5;
    cycle();  chk("wr_ce", 32'(s_ce), 32'd1);
    chk("wr_addr", 32'(s_addr), 32'h10);  chk("wr_din", 32'(s_din), 32'hA5);
    bus.WE0 = 1'b0;
    cycle();  chk("rd_ce", 32'(s_ce), 32'd0);
    bus.REQ0 = 1'b0;
    cycle();  chk("rd_rvalid", 32'(s_rvalid0), 32'd1);  chk("rd_rdata", 32'(s_rdata0), 32'hA5);
    cycle();  chk("rvalid_pulse", 32'(s_rvalid0), 32'd0);
    chk("release_gnt0", 32'(s_gnt0), 32'd0);  chk("release_ce", 32'(s_ce), 32'd0);

    // Tie right after reset: core first, then aux.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.REQ0 = 1'b1; bus.WE0 = 1'b0; bus.ADDR0 = 8'h10;
    bus.REQ1 = 1'b1; bus.WE1 = 1'b0; bus.ADDR1 = 8'h33;
    cycle();
    cycle();  chk("tie1_gnt0", 32'(s_gnt0), 32'd1);  chk("tie1_gnt1", 32'(s_gnt1), 32'd0);
    bus.REQ0 = 1'b0;
    cycle();
    cycle();  chk("tie1_then_gnt1", 32'(s_gnt1), 32'd1);
    bus.REQ1 = 1'b0;
    cycle();  chk("aux_rvalid", 32'(s_rvalid1), 32'd1);  chk("aux_rdata", 32'(s_rdata1), 32'h77);

    // Core-only access, then a second tie which the aux wins.
    bus.REQ0 = 1'b1; bus.WE0 = 1'b1; bus.ADDR0 = 8'h20; bus.WDATA0 = 8'h5A;
    cycle();  cycle();
    bus.REQ0 = 1'b0;
    cycle();
    bus.REQ0 = 1'b1; bus.WE0 = 1'b0; bus.ADDR1 = 8'h20; bus.REQ1 = 1'b1;
    cycle();
    cycle();  chk("tie2_gnt1", 32'(s_gnt1), FIXED ? 32'd0 : 32'd1);
    chk("tie2_stall0", 32'(s_stall0), FIXED ? 32'd0 : 32'd1);
    bus.REQ1 = 1'b0;
    cycle();  cycle();
    bus.REQ0 = 1'b0;
    cycle();  cycle();

    // Burst fairness: core held 10 cycles while aux competes.
    bus.REQ0 = 1'b1; bus.WE0 = 1'b0; bus.ADDR0 = 8'h10;
    cycle();
    bus.REQ1 = 1'b1; bus.WE1 = 1'b1; bus.ADDR1 = 8'h40; bus.WDATA1 = 8'hC3;
    run0 = 0; seen1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) bus.REQ1 = 1'b0;
      cycle();
      if (s_gnt1) begin
        seen1 = 1'b1;
        chk("burst_stall0", 32'(s_stall0), 32'd1);
      end else if (!seen1 && s_gnt0) begin
        run0++;
      end
    end
    chk("burst_core_run", 32'(run0), FIXED ? 32'd10 : 32'd4);
    chk("core_resumed", 32'(s_gnt0), 32'd1);

    // Aux owning when the core raises its request.
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b1; bus.WE1 = 1'b1; bus.ADDR1 = 8'h41; bus.WDATA1 = 8'h3C;
    cycle();  cycle();  cycle();
    bus.REQ0 = 1'b1; bus.WE0 = 1'b0; bus.ADDR0 = 8'h41;
    cycle();
    cycle();  chk("prio_gnt0", 32'(s_gnt0), FIXED ? 32'd1 : 32'd0);
    cycle();  chk("handover_gnt0", 32'(s_gnt0), 32'd1);
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    cycle();  cycle();  cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
